// File: rtl/serial_rx.sv
// 8N1 UART receiver, LSB first: two-flop resync, mid-bit sampling, one-cycle
// data_valid / frame_err strobes. data_out holds the last good byte.
//   state | meaning
//   IDLE  | line idle, waiting for rx_s low
//   START | half-bit wait, then confirm start bit is still low
//   DATA  | sample 8 data bits, one per bit period
//   STOP  | sample stop bit, deliver byte or flag framing error
//   FLUSH | after framing error, wait for line to return high
module serial_rx #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int CNT_W        = 13
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       serialIn,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_FLUSH
   } state_t;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_err;
   logic             r_busy;
   logic             r_sync1;
   logic             r_rx_s;

   // Sync flops reset high so a reset never looks like a start edge.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= serialIn;
         r_rx_s  <= r_sync1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt <= '0;
                  if (!r_rx_s) begin
                     r_state <= S_DATA;
                     r_idx   <= '0;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt          <= '0;
                  r_shift[r_idx] <= r_rx_s;
                  if (r_idx == 3'd7) r_state <= S_STOP;
                  else               r_idx   <= r_idx + 3'd1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt <= '0;
                  if (r_rx_s) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= S_FLUSH;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_FLUSH: begin
               // A held-low break must not re-trigger a frame.
               if (r_rx_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign frame_err  = r_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx at 16 clk/bit: frames are described at byte level,
// expected strobes are queued at send time and a monitor pops them as the DUT strobes.
module tb_serial_rx;

   localparam int CPB     = 16;
   localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       sysclk = 1'b0;
   logic       reset;
   logic       serialIn;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   busy_cycles = 0;
   logic [7:0] last_good = 8'h00;
   exp_t exp_q[$];

   serial_rx #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .serialIn  (serialIn),
      .data_out  (data_out),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;
   always @(negedge sysclk) if (busy) busy_cycles <= busy_cycles + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge sysclk) begin
      if (!reset && (data_valid || frame_err)) begin
         chk("strobe_exclusive", int'(data_valid & frame_err), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", int'(frame_err), -1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("strobe_kind_frame_err", int'(frame_err), int'(e.is_err));
            chk("strobe_data_out", int'(data_out), int'(e.data));
            chk("strobe_latency", cyc, e.cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic tx_level(input logic v, input int n);
      serialIn = v;
      tick(n);
   endtask

   // Reference: a good frame yields its byte, a low stop bit yields frame_err with
   // data_out unchanged; either strobe lands a fixed latency after the start edge.
   task automatic send_frame(input logic [7:0] b, input int cpb, input bit stop_ok);
      exp_t e;
      e.is_err = !stop_ok;
      e.data   = stop_ok ? b : last_good;
      e.cyc    = cyc + LATENCY;
      exp_q.push_back(e);
      if (stop_ok) last_good = b;
      tx_level(1'b0, cpb);
      for (int i = 0; i < 8; i++) tx_level(b[i], cpb);
      tx_level(stop_ok, cpb);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout_pending", exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] a5;
      reset    = 1'b1;
      serialIn = 1'b1;
      tick(3);
      chk("reset_data_out", int'(data_out), 0);
      chk("reset_data_valid", int'(data_valid), 0);
      chk("reset_frame_err", int'(frame_err), 0);
      chk("reset_busy", int'(busy), 0);
      reset = 1'b0;
      tick(10);

      // 1: single frame
      send_frame(8'h41, CPB, 1'b1);
      tx_level(1'b1, 20);
      drain(200);

      // 2: zero-gap pair
      send_frame(8'h68, CPB, 1'b1);
      send_frame(8'h08, CPB, 1'b1);
      tx_level(1'b1, 20);
      drain(200);

      // 3: short glitch
      busy_cycles = 0;
      tx_level(1'b0, 5);
      tx_level(1'b1, 30);
      chk("glitch_busy_cycles", busy_cycles, CPB / 2);
      chk("glitch_busy_after", int'(busy), 0);

      // 4: framing error followed by a long break
      send_frame(8'h55, CPB, 1'b0);
      tx_level(1'b0, 200);
      chk("break_busy_held", int'(busy), 1);
      chk("break_data_out_kept", int'(data_out), int'(last_good));
      tx_level(1'b0, 400 - CPB - 200);
      tx_level(1'b1, 20);
      chk("break_busy_released", int'(busy), 0);
      drain(50);

      // 5: reset during bit 3 of 8'hA5, then a clean frame
      a5 = 8'hA5;
      tx_level(1'b0, CPB);
      for (int i = 0; i < 3; i++) tx_level(a5[i], CPB);
      tx_level(a5[3], CPB / 2);
      reset    = 1'b1;
      serialIn = 1'b1;
      tick(1);
      reset     = 1'b0;
      last_good = 8'h00;
      chk("midreset_data_out", int'(data_out), 0);
      chk("midreset_busy", int'(busy), 0);
      tx_level(1'b1, 200);
      chk("midreset_data_out_held", int'(data_out), 0);
      send_frame(8'h3C, CPB, 1'b1);
      tx_level(1'b1, 20);
      drain(200);

      // 6: baud skew
      send_frame(8'hFF, CPB - 1, 1'b1);
      tx_level(1'b1, 40);
      send_frame(8'hFF, CPB + 1, 1'b1);
      tx_level(1'b1, 40);
      drain(200);

      // Random traffic with occasional framing errors and variable gaps.
      for (int f = 0; f < 30; f++) begin
         logic [7:0] b;
         bit ok;
         int gap;
         b   = 8'($urandom);
         ok  = ($urandom_range(0, 7) != 0);
         gap = $urandom_range(0, 12);
         send_frame(b, CPB, ok);
         if (!ok) begin
            tx_level(1'b0, $urandom_range(0, 40));
            if (gap < 2) gap = 2;
         end
         if (gap > 0) tx_level(1'b1, gap);
      end
      tx_level(1'b1, 20);
      drain(400);
      tick(200);
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_busy", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
